// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared widths, source indices, state encoding and round-robin pick for the 80-bit 2:1 arbiter
package mux_arb_pkg;
  localparam int DATA_WIDTH = 80;
  localparam logic SRC_IN0 = 1'b0;
  localparam logic SRC_IN1 = 1'b1;
  localparam logic LASTGRANT_RST = 1'b1;
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;
  // Under contention the requester that did not win last time goes next
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
    return (r0 & r1) ? ~last : r1;
  endfunction
endpackage

// File: rtl/mux_2to1_80bit.sv
// mux_2to1_80bit: plain 80-bit two-input word multiplexer
module mux_2to1_80bit
  import mux_arb_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] In0,
  input  logic [DATA_WIDTH-1:0] In1,
  input  logic                  Select,
  output logic [DATA_WIDTH-1:0] Out
);
  assign Out = Select ? In1 : In0;
endmodule

// File: rtl/mux_arb_2to1_80bit.sv
// mux_arb_2to1_80bit: round-robin arbiter and output register for the 80-bit 2:1 mux; MUX_ARB_LOCK_EN adds grant locking
module mux_arb_2to1_80bit
  import mux_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 80
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Req0,
  input  logic [DATA_WIDTH-1:0] In0,
  input  logic                  Req1,
  input  logic [DATA_WIDTH-1:0] In1,
  output logic                  Ack0,
  output logic                  Ack1,
  output logic [DATA_WIDTH-1:0] Out,
  output logic                  OutSrc,
  output logic                  OutValid,
  input  logic                  OutReady
`ifdef MUX_ARB_LOCK_EN
  ,
  input  logic                  Lock0,
  input  logic                  Lock1
`endif
);
  state_t state_q, state_d;
  logic last_q;
  logic elig0, elig1, grant, space, accept;
  logic [DATA_WIDTH-1:0] mux_out;
`ifdef MUX_ARB_LOCK_EN
  logic locked_q, owner_q;
  // While locked the non-owner is masked even if the owner is idle
  always_comb begin
    elig0 = Req0 & (~locked_q | (owner_q == SRC_IN0));
    elig1 = Req1 & (~locked_q | (owner_q == SRC_IN1));
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      locked_q <= 1'b0;
      owner_q  <= SRC_IN0;
    end else if (accept) begin
      locked_q <= grant ? Lock1 : Lock0;
      owner_q  <= grant;
    end
  end
`else
  always_comb begin
    elig0 = Req0;
    elig1 = Req1;
  end
`endif
  always_comb begin
    space  = (state_q == ST_EMPTY) | OutReady;
    grant  = rr_pick(elig0, elig1, last_q);
    accept = ~Reset & space & (elig0 | elig1);
  end
  mux_2to1_80bit u_mux (
    .In0   (In0),
    .In1   (In1),
    .Select(grant),
    .Out   (mux_out)
  );
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = accept ? ST_FULL : (OutReady ? ST_EMPTY : state_q);
  end
  always_comb begin
    Ack0     = accept & (grant == SRC_IN0);
    Ack1     = accept & (grant == SRC_IN1);
    OutValid = (state_q == ST_FULL);
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Out    <= '0;
      OutSrc <= SRC_IN0;
      last_q <= LASTGRANT_RST;
    end else if (accept) begin
      Out    <= mux_out;
      OutSrc <= grant;
      last_q <= grant;
    end
  end
endmodule

// File: tb/tb_mux_arb_2to1_80bit.sv
// tb_mux_arb_2to1_80bit: directed and randomized checks of the 80-bit arbiter against a behavioural model
module tb_mux_arb_2to1_80bit;
  logic Clock = 1'b0, Reset = 1'b1, Req0 = 1'b0, Req1 = 1'b0, OutReady = 1'b0;
  logic [79:0] In0 = '0, In1 = '0, Out;
  logic Ack0, Ack1, OutSrc, OutValid;
`ifdef MUX_ARB_LOCK_EN
  logic Lock0 = 1'b0, Lock1 = 1'b0;
`endif
  mux_arb_2to1_80bit dut (
    .Clock(Clock), .Reset(Reset), .Req0(Req0), .In0(In0), .Req1(Req1), .In1(In1),
    .Ack0(Ack0), .Ack1(Ack1), .Out(Out), .OutSrc(OutSrc), .OutValid(OutValid), .OutReady(OutReady)
`ifdef MUX_ARB_LOCK_EN
    , .Lock0(Lock0), .Lock1(Lock1)
`endif
  );
  always #5 Clock = ~Clock;
  int n_chk = 0, n_fail = 0;
  logic m_known = 1'b0, m_valid = 1'b0, m_src = 1'b0, m_last = 1'b1, m_locked = 1'b0, m_owner = 1'b0;
  logic [79:0] m_out = '0;
  logic e_ack0, e_ack1, o_ack0, o_ack1;
  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [79:0] rnd80();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[79:0];
  endfunction
  // One clock: check combinational acks and registered outputs, then advance the model
  task automatic tick();
    logic e0, e1, g, acc, lk;
    logic [79:0] w;
    @(negedge Clock);
    e0 = Req0 && (!m_locked || !m_owner);
    e1 = Req1 && (!m_locked || m_owner);
    g = (e0 && e1) ? !m_last : e1;
    acc = !Reset && (!m_valid || OutReady) && (e0 || e1);
    e_ack0 = acc && !g;
    e_ack1 = acc && g;
    o_ack0 = Ack0;
    o_ack1 = Ack1;
    w = g ? In1 : In0;
    lk = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    lk = g ? Lock1 : Lock0;
`endif
    check("ack0", 80'(Ack0), 80'(e_ack0));
    check("ack1", 80'(Ack1), 80'(e_ack1));
    if (m_known) begin
      check("valid", 80'(OutValid), 80'(m_valid));
      check("src", 80'(OutSrc), 80'(m_src));
      check("out", Out, m_out);
    end
    @(posedge Clock);
    #1;
    if (Reset) begin
      m_known = 1'b1; m_valid = 1'b0; m_out = '0; m_src = 1'b0;
      m_last = 1'b1; m_locked = 1'b0; m_owner = 1'b0;
    end else if (acc) begin
      m_out = w; m_src = g; m_last = g; m_valid = 1'b1; m_locked = lk; m_owner = g;
    end else if (OutReady) m_valid = 1'b0;
  endtask
  initial begin
    logic [79:0] A, B, C, D;
    int n0, n1;
    A = 80'hA; B = 80'hB; C = rnd80(); D = rnd80();
    Reset = 1; Req0 = 1; Req1 = 1;
    tick();
    check("rst_ack_a", 80'(o_ack0 | o_ack1), 80'd0);
    tick();
    check("rst_ack_b", 80'(o_ack0 | o_ack1), 80'd0);
    Reset = 0; Req0 = 0; Req1 = 0; OutReady = 1;
    tick();
    check("rst_valid", 80'(OutValid), 80'd0);
    check("rst_out", Out, 80'd0);
    Req0 = 1; In0 = 80'h1;
    tick();
    Req0 = 0;
    check("single_ack0", 80'(o_ack0), 80'd1);
    check("single_out", Out, 80'h1);
    check("single_src", 80'(OutSrc), 80'd0);
    check("single_valid", 80'(OutValid), 80'd1);
    Reset = 1;
    tick();
    Reset = 0; Req0 = 1; Req1 = 1; In0 = A; In1 = B;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr_out", Out, (i % 2) ? B : A);
      check("rr_src", 80'(OutSrc), 80'(i % 2));
    end
    OutReady = 0; Req0 = 0; Req1 = 1; In1 = C;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_ack1", 80'(o_ack1), 80'd0);
      check("stall_out", Out, B);
    end
    OutReady = 1;
    tick();
    Req1 = 0;
    check("unstall_ack1", 80'(o_ack1), 80'd1);
    check("unstall_out", Out, C);
    check("unstall_src", 80'(OutSrc), 80'd1);
    OutReady = 0; Req0 = 1; In0 = D; Reset = 1;
    tick();
    check("midrst_ack", 80'(o_ack0 | o_ack1), 80'd0);
    check("midrst_valid", 80'(OutValid), 80'd0);
    check("midrst_out", Out, 80'd0);
    Reset = 0; Req1 = 1; OutReady = 1;
    tick();
    check("midrst_first", 80'(o_ack0), 80'd1);
    check("midrst_word", Out, D);
    Req0 = 0; Req1 = 0;
    tick();
`ifdef MUX_ARB_LOCK_EN
    Reset = 1;
    tick();
    Reset = 0; Req1 = 1; Lock1 = 1; n0 = 0; n1 = 0;
    for (int k = 0; k < 4; k++) begin
      Lock1 = (k < 3);
      In1 = rnd80();
      tick();
      Req0 = 1;
      n0 += int'(o_ack0);
      n1 += int'(o_ack1);
    end
    check("lock_ack1_cnt", 80'(n1), 80'd4);
    check("lock_ack0_cnt", 80'(n0), 80'd0);
    tick();
    check("unlock_ack0", 80'(o_ack0), 80'd1);
    Req0 = 0; Req1 = 0; Lock1 = 0;
    tick();
`endif
    n0 = 0; n1 = 0;
    for (int c = 0; c < 3000; c++) begin
      if (e_ack0 || !Req0) begin
        Req0 = e_ack0 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
        In0 = rnd80();
`ifdef MUX_ARB_LOCK_EN
        Lock0 = ($urandom_range(0, 3) == 0);
`endif
      end
      if (e_ack1 || !Req1) begin
        Req1 = e_ack1 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
        In1 = rnd80();
`ifdef MUX_ARB_LOCK_EN
        Lock1 = ($urandom_range(0, 3) == 0);
`endif
      end
      OutReady = ($urandom_range(0, 3) != 0);
      Reset = ($urandom_range(0, 199) == 0);
      tick();
      n0 += int'(o_ack0);
      n1 += int'(o_ack1);
      if (o_ack0 && o_ack1) check("ack_exclusive", 80'd1, 80'd0);
    end
    check("rand_saw_ack0", 80'(n0 > 100), 80'd1);
    check("rand_saw_ack1", 80'(n1 > 100), 80'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
